// File: rtl/alu_shift_pkg.sv
// Shared definitions for the ALU shift path: widths, shift modes and the
// per-stage operation payload carried down the right-shift pipeline.
package alu_shift_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SHW   = 4;

  localparam logic [1:0] SH_LOGIC = 2'b00;
  localparam logic [1:0] SH_ARITH = 2'b01;
  localparam logic [1:0] SH_ROT   = 2'b10;

  typedef struct packed {
    logic [SHW-1:0]   ctrl;
    logic [1:0]       mode;
    logic             fill;
    logic [WIDTH-1:0] data;
  } shift_op_t;

endpackage

// File: rtl/rshift_stage.sv
// One registered log-shift stage: shifts right by AMT when its ctrl bit is set,
// with a local valid bit and elastic load/ready logic.
module rshift_stage
  import alu_shift_pkg::*;
#(
  parameter int unsigned AMT = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_valid,
  input  shift_op_t i_op,
  input  logic      i_down_ready,
  output logic      o_ready_c,
  output logic      o_valid,
  output shift_op_t o_op
);

  localparam int unsigned CBIT = $clog2(AMT);

  logic      r_valid;
  shift_op_t r_op;
  shift_op_t w_next;

  // Rotate recirculates the low bits; other modes shift in the captured fill bit.
  always_comb begin
    w_next = i_op;
    if (i_op.ctrl[CBIT]) begin
      if (i_op.mode == SH_ROT) begin
        w_next.data = {i_op.data[AMT-1:0], i_op.data[WIDTH-1:AMT]};
      end else begin
        w_next.data = {{AMT{i_op.fill}}, i_op.data[WIDTH-1:AMT]};
      end
    end
  end

  assign o_ready_c = !r_valid || i_down_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_op    <= '0;
    end else if (o_ready_c) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_op <= w_next;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_op    = r_op;

endmodule

// File: rtl/barrel_rshift_pipe_16bit.sv
// Four-stage pipelined 16-bit right barrel shifter (logical, arithmetic, rotate)
// with valid/ready on both sides and a combinational ready chain.
module barrel_rshift_pipe_16bit
  import alu_shift_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  input  logic [SHW-1:0]   ctrl,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  logic      w_valid [0:SHW];
  logic      w_ready [0:SHW];
  shift_op_t w_op    [0:SHW];
  logic      w_unused_tail;

  // Fill bit is latched once at accept so later stages need no sign logic.
  always_comb begin
    w_op[0].ctrl = ctrl;
    w_op[0].mode = mode;
    w_op[0].fill = (mode == SH_ARITH) ? in[WIDTH-1] : 1'b0;
    w_op[0].data = in;
  end

  assign w_valid[0]   = in_valid;
  assign w_ready[SHW] = out_ready;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    rshift_stage #(
      .AMT(WIDTH >> (k + 1))
    ) u_stage (
      .clk         (clk),
      .rst         (rst),
      .i_valid     (w_valid[k]),
      .i_op        (w_op[k]),
      .i_down_ready(w_ready[k+1]),
      .o_ready_c   (w_ready[k]),
      .o_valid     (w_valid[k+1]),
      .o_op        (w_op[k+1])
    );
  end

  always_comb begin
    busy = 1'b0;
    for (int unsigned k = 1; k <= SHW; k++) begin
      busy = busy | w_valid[k];
    end
  end

  assign in_ready      = w_ready[0] & ~rst;
  assign out_valid     = w_valid[SHW];
  assign out           = w_op[SHW].data;
  assign w_unused_tail = ^{w_op[SHW].ctrl, w_op[SHW].mode, w_op[SHW].fill};

endmodule

// File: tb/tb_barrel_rshift_pipe_16bit.sv
// Bench for barrel_rshift_pipe_16bit: directed cases, backpressure, random
// streaming against a queue-based reference, and mid-stream reset.
module tb_barrel_rshift_pipe_16bit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_d = '0;
  logic [3:0]  ctrl = '0;
  logic [1:0]  mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out;
  logic        busy;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  barrel_rshift_pipe_16bit dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in       (in_d),
    .ctrl     (ctrl),
    .mode     (mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .busy     (busy)
  );

  function automatic logic [15:0] ref_shift(logic [15:0] x, logic [3:0] c, logic [1:0] m);
    logic [31:0] dbl;
    case (m)
      2'b01:   return 16'($signed(x) >>> c);
      2'b10: begin
        dbl = {x, x} >> c;
        return dbl[15:0];
      end
      default: return x >> c;
    endcase
  endfunction

  task automatic check_eq(string tag, logic [15:0] got, logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs shortly after the edge, then let the ready chain settle.
  task automatic cyc(logic iv, logic [15:0] d, logic [3:0] c, logic [1:0] m, logic ordy);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_d      = d;
    ctrl      = c;
    mode      = m;
    out_ready = ordy;
    #1;
  endtask

  task automatic run_one(string tag, logic [15:0] d, logic [3:0] c, logic [1:0] m,
                         logic [15:0] exp);
    int lat;
    cyc(1'b1, d, c, m, 1'b1);
    check_eq({tag, " accept"}, 16'(in_ready), 16'd1);
    lat = 11;
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b0, 16'h0, 4'h0, 2'b00, 1'b1);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    check_eq({tag, " latency"}, 16'(lat), 16'd4);
    check_eq({tag, " data"}, out, exp);
  endtask

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    int idx;
    int rcv;
    int iters;
    int accepted;
    logic        iv;
    logic        ordy;
    logic        prev_stall;
    logic [15:0] prev_out;
    logic [15:0] d;
    logic [3:0]  c;
    logic [1:0]  m;

    // Reset state
    #1 rst = 1'b1;
    #2;
    check_eq("rst out_valid", 16'(out_valid), 16'd0);
    check_eq("rst busy", 16'(busy), 16'd0);
    check_eq("rst out", out, 16'h0000);
    check_eq("rst in_ready", 16'(in_ready), 16'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_eq("post-rst in_ready", 16'(in_ready), 16'd1);

    // Directed single operations
    run_one("lsr 8000>>4", 16'h8000, 4'd4, 2'b00, 16'h0800);
    run_one("lsr ffff>>15", 16'hFFFF, 4'd15, 2'b00, 16'h0001);
    run_one("asr 8000>>4", 16'h8000, 4'd4, 2'b01, 16'hF800);
    run_one("asr 8000>>15", 16'h8000, 4'd15, 2'b01, 16'hFFFF);
    run_one("asr 7ff0>>4", 16'h7FF0, 4'd4, 2'b01, 16'h07FF);
    run_one("ror 0001>>1", 16'h0001, 4'd1, 2'b10, 16'h8000);
    run_one("ror 1234>>8", 16'h1234, 4'd8, 2'b10, 16'h3412);
    run_one("mode3 ctrl0", 16'h1234, 4'd0, 2'b11, 16'h1234);

    // Backpressure: fill pipeline with out_ready low
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      iv = (idx < 6);
      cyc(iv, 16'(16'h0010 + idx), 4'd4, 2'b00, 1'b0);
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_shift(in_d, ctrl, mode));
        idx++;
      end
    end
    check_eq("bp accepted", 16'(idx), 16'd4);
    check_eq("bp in_ready", 16'(in_ready), 16'd0);
    check_eq("bp out_valid", 16'(out_valid), 16'd1);
    check_eq("bp out held", out, 16'h0001);

    rcv = 0;
    iters = 0;
    while (rcv < 6 && iters < 20) begin
      iv = (idx < 6);
      cyc(iv, 16'(16'h0010 + idx), 4'd4, 2'b00, 1'b1);
      iters++;
      if (out_valid) begin
        check_eq("bp drain", out, exp_q.pop_front());
        rcv++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_shift(in_d, ctrl, mode));
        idx++;
      end
    end
    check_eq("bp received", 16'(rcv), 16'd6);
    check_eq("bp drain cycles", 16'(iters), 16'd6);
    cyc(1'b0, 16'h0, 4'h0, 2'b00, 1'b1);
    check_eq("bp idle busy", 16'(busy), 16'd0);

    // Random streaming against the reference queue
    exp_q.delete();
    accepted   = 0;
    prev_stall = 1'b0;
    prev_out   = '0;
    iters      = 0;
    while (!(accepted == 1000 && exp_q.size() == 0) && iters < 20000) begin
      iv   = (accepted < 1000) && ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      d    = 16'($urandom());
      c    = 4'($urandom_range(0, 15));
      m    = 2'($urandom_range(0, 3));
      cyc(iv, d, c, m, ordy);
      iters++;
      if (prev_stall) begin
        check_eq("rnd hold valid", 16'(out_valid), 16'd1);
        check_eq("rnd hold data", out, prev_out);
      end
      check_eq("rnd busy", 16'(busy), 16'(exp_q.size() != 0));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_eq("rnd spurious", 16'(out_valid), 16'd0);
        else                   check_eq("rnd data", out, exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_shift(in_d, ctrl, mode));
        accepted++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = out;
    end
    check_eq("rnd accepted", 16'(accepted), 16'd1000);
    check_eq("rnd leftover", 16'(exp_q.size()), 16'd0);

    // Reset with operations in flight
    run_one("pre-rst", 16'h1234, 4'd0, 2'b00, 16'h1234);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 16'(16'hA5A0 + k), 4'd1, 2'b01, 1'b1);
    end
    cyc(1'b0, 16'h0, 4'h0, 2'b00, 1'b1);
    check_eq("mid busy before rst", 16'(busy), 16'd1);
    rst = 1'b1;
    #1;
    check_eq("mid rst out_valid", 16'(out_valid), 16'd0);
    check_eq("mid rst busy", 16'(busy), 16'd0);
    check_eq("mid rst out", out, 16'h0000);
    check_eq("mid rst in_ready", 16'(in_ready), 16'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_eq("mid post-rst in_ready", 16'(in_ready), 16'd1);
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 16'h0, 4'h0, 2'b00, 1'b1);
      check_eq("no stale result", 16'(out_valid), 16'd0);
    end
    run_one("after rst", 16'h00F0, 4'd4, 2'b00, 16'h000F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
